// File: rtl/vxe_mem_hub_mas_ds_pkg.sv
// vxe_mem_hub_mas_ds_pkg: shared hub encodings for the master-port downstream path
package vxe_mem_hub_mas_ds_pkg;
   localparam int TXNID_W   = 6;
   localparam int ERR_W     = 2;
   localparam int RNW_W     = 1;
   localparam int RNW_BIT   = 0;
   localparam int ERR_LSB   = RNW_BIT + RNW_W;
   localparam int TXNID_LSB = ERR_LSB + ERR_W;
   localparam int CID_LSB   = TXNID_LSB + 4;
   localparam int RSS_W     = TXNID_W + ERR_W + RNW_W;
   localparam int DATA_W    = 64;
   localparam int RS_W      = RSS_W + DATA_W;
   typedef enum logic [1:0] {CID_CU = 2'b00, CID_VPU0 = 2'b01, CID_VPU1 = 2'b10, CID_RSVD = 2'b11} cid_e;
   typedef enum logic [1:0] {RX_IDLE = 2'b00, RX_RSS = 2'b01, RX_DATA = 2'b10, RX_STLL = 2'b11} rx_state_e;
   typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_e;
endpackage

// File: rtl/vxe_mem_hub_mas_ds_tx.sv
// vxe_mem_hub_mas_ds_tx: one client's 4-entry response FIFO and its registered write stage
module vxe_mem_hub_mas_ds_tx
   import vxe_mem_hub_mas_ds_pkg::*;
(
   input  logic            clk,
   input  logic            nrst,
   input  logic            push,
   input  logic [RS_W-1:0] push_data,
   input  logic            rdy,
   output logic            full,
   output logic            pre_full,
   output logic [RS_W-1:0] rs,
   output logic            wr
);
   logic [RS_W-1:0] mem [4];
   logic [2:0] wp, rp, cnt;
   logic empty, pop;
   tx_state_e state, state_n;
   assign cnt = wp - rp;
   assign empty = wp == rp;
   assign full = wp[1:0] == rp[1:0] && wp[2] != rp[2];
   assign pre_full = cnt == 3'd3;
   // FIFO storage, no reset needed since pointers gate every read
   always_ff @(posedge clk)
      if (push) mem[wp[1:0]] <= push_data;
   // state, pointers and output word
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         state <= TX_IDLE;
         wp <= '0;
         rp <= '0;
         rs <= '0;
      end else begin
         state <= state_n;
         if (push) wp <= wp + 3'd1;
         if (pop) begin
            rs <= mem[rp[1:0]];
            rp <= rp + 3'd1;
         end
      end
   // next state: any queued word keeps or moves us into SEND; a drained, accepted SEND goes idle
   always_comb
      state_n = !empty ? TX_SEND : (state == TX_SEND && rdy) ? TX_IDLE : state;
   // outputs: pop whenever the output stage is free or being accepted
   always_comb begin
      pop = !empty && (state == TX_IDLE || rdy);
      wr = state == TX_SEND;
   end
endmodule

// File: rtl/vxe_mem_hub_mas_ds.sv
// vxe_mem_hub_mas_ds: routes master-port responses to CU/VPU0/VPU1 by txnid[5:4]
// Option macro VXE_MEM_HUB_DS_ROUTE_CHECK_EN: drop client ID 2'b11 and pulse o_err_route
module vxe_mem_hub_mas_ds
   import vxe_mem_hub_mas_ds_pkg::*;
(
   input  logic              clk,
   input  logic              nrst,
   input  logic              i_m_rss_vld,
   input  logic [RSS_W-1:0]  i_m_rss,
   output logic              o_m_rss_rd,
   input  logic              i_m_rsd_vld,
   input  logic [DATA_W-1:0] i_m_rsd,
   output logic              o_m_rsd_rd,
   input  logic              i_cu_rs_rdy,
   input  logic              i_vpu0_rs_rdy,
   input  logic              i_vpu1_rs_rdy,
   output logic [RS_W-1:0]   o_cu_rs,
   output logic [RS_W-1:0]   o_vpu0_rs,
   output logic [RS_W-1:0]   o_vpu1_rs,
   output logic              o_cu_rs_wr,
   output logic              o_vpu0_rs_wr,
   output logic              o_vpu1_rs_wr,
   output logic              o_err_route
);
   rx_state_e state, state_n;
   logic [RSS_W-1:0] hold;
   logic [RS_W-1:0] push_word;
   logic [1:0] push_cid, cid;
   logic [2:0] push, full, pre_full;
   logic rss_acc, rsd_acc, in_data, push_any, stall, rss_rd_n, rsd_rd_n;
   assign rss_acc = i_m_rss_vld && o_m_rss_rd;
   assign rsd_acc = i_m_rsd_vld && o_m_rsd_rd;
   assign stall = |{full, pre_full};
   assign in_data = state == RX_DATA;
   assign push_word = in_data ? {hold, i_m_rsd} : {i_m_rss, {DATA_W{1'b0}}};
   assign push_cid = in_data ? hold[CID_LSB +: 2] : i_m_rss[CID_LSB +: 2];
   assign push_any = in_data ? rsd_acc : state == RX_RSS && rss_acc && !i_m_rss[RNW_BIT];
   assign push[0] = push_any && cid == CID_CU;
   assign push[1] = push_any && cid == CID_VPU0;
   assign push[2] = push_any && cid == CID_VPU1;
`ifdef VXE_MEM_HUB_DS_ROUTE_CHECK_EN
   assign cid = push_cid;
   // flag the edge on which a reserved-ID response is consumed without a push
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) o_err_route <= 1'b0;
      else o_err_route <= push_any && push_cid == CID_RSVD;
`else
   assign cid = push_cid[1] ? CID_VPU1 : push_cid;
   assign o_err_route = 1'b0;
`endif
   // Rx state, registered read enables and read-status hold
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         state <= RX_IDLE;
         o_m_rss_rd <= 1'b0;
         o_m_rsd_rd <= 1'b0;
         hold <= '0;
      end else begin
         state <= state_n;
         o_m_rss_rd <= rss_rd_n;
         o_m_rsd_rd <= rsd_rd_n;
         if (state == RX_RSS && rss_acc && i_m_rss[RNW_BIT]) hold <= i_m_rss;
      end
   // next state: a read status beats the stall check; stall is rechecked after every data word
   always_comb begin
      state_n = state;
      case (state)
         RX_IDLE: state_n = RX_RSS;
         RX_RSS:  state_n = (rss_acc && i_m_rss[RNW_BIT]) ? RX_DATA : stall ? RX_STLL : RX_RSS;
         RX_DATA: state_n = !rsd_acc ? RX_DATA : stall ? RX_STLL : RX_RSS;
         RX_STLL: state_n = stall ? RX_STLL : RX_RSS;
         default: state_n = RX_IDLE;
      endcase
   end
   // outputs: each read enable is high exactly while its state is current
   always_comb begin
      rss_rd_n = state_n == RX_RSS;
      rsd_rd_n = state_n == RX_DATA;
   end
   vxe_mem_hub_mas_ds_tx u_cu (
      .clk(clk), .nrst(nrst), .push(push[0]), .push_data(push_word), .rdy(i_cu_rs_rdy),
      .full(full[0]), .pre_full(pre_full[0]), .rs(o_cu_rs), .wr(o_cu_rs_wr));
   vxe_mem_hub_mas_ds_tx u_vpu0 (
      .clk(clk), .nrst(nrst), .push(push[1]), .push_data(push_word), .rdy(i_vpu0_rs_rdy),
      .full(full[1]), .pre_full(pre_full[1]), .rs(o_vpu0_rs), .wr(o_vpu0_rs_wr));
   vxe_mem_hub_mas_ds_tx u_vpu1 (
      .clk(clk), .nrst(nrst), .push(push[2]), .push_data(push_word), .rdy(i_vpu1_rs_rdy),
      .full(full[2]), .pre_full(pre_full[2]), .rs(o_vpu1_rs), .wr(o_vpu1_rs_wr));
endmodule

// File: tb/tb_vxe_mem_hub_mas_ds.sv
// tb_vxe_mem_hub_mas_ds: scoreboard bench for the master-port downstream router
module tb_vxe_mem_hub_mas_ds;
   logic clk = 1'b0, nrst = 1'b0;
   logic i_m_rss_vld = 1'b0, i_m_rsd_vld = 1'b0;
   logic [8:0] i_m_rss = '0;
   logic [63:0] i_m_rsd = '0;
   logic i_cu_rs_rdy = 1'b1, i_vpu0_rs_rdy = 1'b1, i_vpu1_rs_rdy = 1'b1;
   logic o_m_rss_rd, o_m_rsd_rd, o_cu_rs_wr, o_vpu0_rs_wr, o_vpu1_rs_wr, o_err_route;
   logic [72:0] o_cu_rs, o_vpu0_rs, o_vpu1_rs;
   int checks = 0, errs = 0, err_pulses = 0, drops_exp = 0;
   logic [72:0] q0[$], q1[$], q2[$];
   logic [8:0] last_rss = '0;

   vxe_mem_hub_mas_ds dut (
      .clk(clk), .nrst(nrst),
      .i_m_rss_vld(i_m_rss_vld), .i_m_rss(i_m_rss), .o_m_rss_rd(o_m_rss_rd),
      .i_m_rsd_vld(i_m_rsd_vld), .i_m_rsd(i_m_rsd), .o_m_rsd_rd(o_m_rsd_rd),
      .i_cu_rs_rdy(i_cu_rs_rdy), .i_vpu0_rs_rdy(i_vpu0_rs_rdy), .i_vpu1_rs_rdy(i_vpu1_rs_rdy),
      .o_cu_rs(o_cu_rs), .o_vpu0_rs(o_vpu0_rs), .o_vpu1_rs(o_vpu1_rs),
      .o_cu_rs_wr(o_cu_rs_wr), .o_vpu0_rs_wr(o_vpu0_rs_wr), .o_vpu1_rs_wr(o_vpu1_rs_wr),
      .o_err_route(o_err_route));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int route(input logic [8:0] s);
`ifdef VXE_MEM_HUB_DS_ROUTE_CHECK_EN
      return (s[8:7] == 2'b11) ? 3 : int'(s[8:7]);
`else
      return s[8] ? 2 : int'(s[7]);
`endif
   endfunction

   task automatic expect_rs(input logic [8:0] s, input logic [63:0] d);
      case (route(s))
         0: q0.push_back({s, d});
         1: q1.push_back({s, d});
         2: q2.push_back({s, d});
         default: drops_exp++;
      endcase
   endtask

   task automatic rcv(input int c, input logic [72:0] got);
      logic [72:0] e;
      e = 'x;
      if (c == 0 && q0.size() != 0) e = q0.pop_front();
      if (c == 1 && q1.size() != 0) e = q1.pop_front();
      if (c == 2 && q2.size() != 0) e = q2.pop_front();
      check($sformatf("client%0d_rs", c), got, e);
   endtask

   always @(negedge clk) begin
      if (o_cu_rs_wr && i_cu_rs_rdy) rcv(0, o_cu_rs);
      if (o_vpu0_rs_wr && i_vpu0_rs_rdy) rcv(1, o_vpu0_rs);
      if (o_vpu1_rs_wr && i_vpu1_rs_rdy) rcv(2, o_vpu1_rs);
      if (o_err_route) err_pulses++;
   end

   task automatic put_rss(input logic [8:0] s);
      int n = 0;
      i_m_rss_vld = 1'b1;
      i_m_rss = s;
      while (!o_m_rss_rd && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("rss_accept_in_time", n < 100, 1'b1);
      @(posedge clk); #1;
      i_m_rss_vld = 1'b0;
      last_rss = s;
      if (!s[0]) expect_rs(s, 64'h0);
   endtask

   task automatic put_rsd(input logic [63:0] d);
      int n = 0;
      i_m_rsd_vld = 1'b1;
      i_m_rsd = d;
      while (!o_m_rsd_rd && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("rsd_accept_in_time", n < 100, 1'b1);
      @(posedge clk); #1;
      i_m_rsd_vld = 1'b0;
      expect_rs(last_rss, d);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q0.size() + q1.size() + q2.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain", q0.size() + q1.size() + q2.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_rss_rd", o_m_rss_rd, 1'b0);
      check("reset_rsd_rd", o_m_rsd_rd, 1'b0);
      check("reset_wr", {o_cu_rs_wr, o_vpu0_rs_wr, o_vpu1_rs_wr}, 3'b000);
      check("reset_rs", o_cu_rs | o_vpu0_rs | o_vpu1_rs, 73'h0);
      check("reset_err", o_err_route, 1'b0);
      #3 nrst = 1'b1;
      // single CU write: output strobe for exactly one cycle, second edge after accept
      put_rss(9'h000);
      check("cu_wr_lat_e1", o_cu_rs_wr, 1'b0);
      @(posedge clk); #1;
      check("cu_wr_lat_e2", o_cu_rs_wr, 1'b1);
      check("cu_rs_word", o_cu_rs, {9'h000, 64'h0});
      @(posedge clk); #1;
      check("cu_wr_one_cycle", o_cu_rs_wr, 1'b0);
      wait_drain();
      // VPU0 read: status then data, data enable only in DATA
      check("rsd_rd_idle", o_m_rsd_rd, 1'b0);
      put_rss({6'h12, 2'b00, 1'b1});
      check("rss_rd_in_data", o_m_rss_rd, 1'b0);
      check("rsd_rd_in_data", o_m_rsd_rd, 1'b1);
      put_rsd(64'hDEAD_BEEF_0123_4567);
      check("rsd_rd_after_data", o_m_rsd_rd, 1'b0);
      wait_drain();
      // six VPU1 writes against a stalled client
      i_vpu1_rs_rdy = 1'b0;
      fork
         for (int k = 0; k < 6; k++) put_rss({6'h20 + 6'(k), 2'(k), 1'b0});
         begin
            repeat (12) @(posedge clk);
            #1;
            check("stall_rss_rd", o_m_rss_rd, 1'b0);
            check("stall_hold_wr", o_vpu1_rs_wr, 1'b1);
            check("stall_hold_rs", o_vpu1_rs, {9'h100, 64'h0});
            i_vpu1_rs_rdy = 1'b1;
         end
      join
      wait_drain();
      // interleaved traffic to all three clients
      put_rss({6'h05, 2'b01, 1'b1});
      put_rsd(64'h1111_2222_3333_4444);
      put_rss({6'h1A, 2'b10, 1'b0});
      put_rss({6'h2C, 2'b00, 1'b1});
      put_rsd(64'hAAAA_5555_CCCC_0F0F);
      wait_drain();
      // reserved client ID: dropped with error pulse, or delivered to VPU1
      put_rss({6'h30, 2'b00, 1'b1});
      put_rsd(64'hFEED_FACE_CAFE_F00D);
      check("rsvd_data_consumed", o_m_rsd_rd, 1'b0);
      put_rss({6'h3F, 2'b11, 1'b0});
      wait_drain();
      check("rsvd_err_pulses", err_pulses, drops_exp);
      // asynchronous reset while CU holds queued responses
      i_cu_rs_rdy = 1'b0;
      put_rss(9'h008);
      put_rss(9'h010);
      put_rss(9'h018);
      @(posedge clk); #2;
      nrst = 1'b0;
      #1;
      check("rst_cu_wr", o_cu_rs_wr, 1'b0);
      check("rst_cu_rs", o_cu_rs, 73'h0);
      check("rst_rss_rd", o_m_rss_rd, 1'b0);
      check("rst_rsd_rd", o_m_rsd_rd, 1'b0);
      q0.delete();
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      i_cu_rs_rdy = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("rst_no_stale_wr", o_cu_rs_wr, 1'b0);
      check("rst_no_stale_rs", o_cu_rs, 73'h0);
      put_rss(9'h020);
      wait_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end
endmodule
